// File: rtl/csr_test_reporter.sv
// Watches tohost CSR writes and latches a PASS/FAIL/TIMEOUT verdict with a frozen cycle count.
// Optional 8N1 UART verdict report is built only when TEST_STATUS_UART_EN is defined.
module csr_test_reporter #(
    parameter int unsigned CLOCK_FREQ     = 50_000_000,
    parameter int unsigned BAUD_RATE      = 115_200,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_csr_we,
    input  logic [31:0] i_csr_wdata,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_fail,
    output logic        o_timeout,
    output logic [31:0] o_fail_code,
    output logic [31:0] o_cycle_count,
    output logic        o_serial_out,
    output logic        o_uart_busy
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun,
        StPass,
        StFail,
        StTimeout
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_cycle_count;
    logic [31:0] r_fail_code;
    logic        w_verdict;

    // A write in the timeout cycle takes priority over the timeout.
    always_comb begin
        w_state_next = r_state;
        if (r_state == StRun) begin
            if (i_csr_we) begin
                if (i_csr_wdata == 32'd1) begin
                    w_state_next = StPass;
                end else if (i_csr_wdata != 32'd0) begin
                    w_state_next = StFail;
                end
            end else if (r_cycle_count == TIMEOUT_LAST) begin
                w_state_next = StTimeout;
            end
        end
    end

    assign w_verdict = (r_state == StRun) && (w_state_next != StRun);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StRun;
            r_cycle_count <= 32'd0;
            r_fail_code   <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (!w_verdict && r_state == StRun) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            if (w_verdict && w_state_next == StFail) begin
                r_fail_code <= i_csr_wdata;
            end
        end
    end

    assign o_done        = (r_state != StRun);
    assign o_pass        = (r_state == StPass);
    assign o_fail        = (r_state == StFail);
    assign o_timeout     = (r_state == StTimeout);
    assign o_fail_code   = r_fail_code;
    assign o_cycle_count = r_cycle_count;

`ifdef TEST_STATUS_UART_EN
    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic [BAUD_W-1:0] r_baud_cnt;
    logic [3:0]        r_bit_cnt;
    logic [2:0]        r_byte_cnt;
    logic [9:0]        r_frame;
    logic [31:0]       r_payload;
    logic              r_busy;
    logic [7:0]        w_status_byte;

    always_comb begin
        w_status_byte = 8'h54;
        case (w_state_next)
            StPass:  w_status_byte = 8'h50;
            StFail:  w_status_byte = 8'h46;
            default: w_status_byte = 8'h54;
        endcase
    end

    // r_frame holds {stop, data, start}; bit 0 drives the line and idles at 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_byte_cnt <= 3'd0;
            r_frame    <= '1;
            r_payload  <= 32'd0;
            r_busy     <= 1'b0;
        end else if (w_verdict) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_byte_cnt <= 3'd0;
            r_frame    <= {1'b1, w_status_byte, 1'b0};
            r_payload  <= r_cycle_count;
            r_busy     <= 1'b1;
        end else if (r_busy) begin
            if (r_baud_cnt == BAUD_LAST) begin
                r_baud_cnt <= '0;
                if (r_bit_cnt == 4'd9) begin
                    r_bit_cnt <= 4'd0;
                    if (r_byte_cnt == 3'd4) begin
                        r_busy  <= 1'b0;
                        r_frame <= '1;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        r_frame    <= {1'b1, r_payload[31:24], 1'b0};
                        r_payload  <= {r_payload[23:0], 8'h00};
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_frame   <= {1'b1, r_frame[9:1]};
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
        end
    end

    assign o_serial_out = r_frame[0];
    assign o_uart_busy  = r_busy;
`else
    assign o_serial_out = 1'b1;
    assign o_uart_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_csr_test_reporter.sv
// Directed bench for csr_test_reporter: verdicts, latency, freezing, reset, and the
// UART report (TEST_STATUS_UART_EN) or its constant idle outputs (default build).
module tb_csr_test_reporter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wdata = 32'd0;
    logic        done, pass, fail, timeout;
    logic [31:0] fail_code, cycle_count;
    logic        serial_out, uart_busy;

    int n_tests = 0;
    int n_fail  = 0;

    csr_test_reporter #(
        .CLOCK_FREQ    (4),
        .BAUD_RATE     (1),
        .TIMEOUT_CYCLES(1000)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_csr_we     (csr_we),
        .i_csr_wdata  (csr_wdata),
        .o_done       (done),
        .o_pass       (pass),
        .o_fail       (fail),
        .o_timeout    (timeout),
        .o_fail_code  (fail_code),
        .o_cycle_count(cycle_count),
        .o_serial_out (serial_out),
        .o_uart_busy  (uart_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench in cycle 0 (cycle_count == 0) after a one-cycle reset.
    task automatic apply_reset();
        @(negedge clk);
        rst    = 1'b1;
        csr_we = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic write_csr(input logic [31:0] v);
        csr_we    = 1'b1;
        csr_wdata = v;
        tick(1);
        csr_we    = 1'b0;
        csr_wdata = 32'd0;
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp_dpft);
        check({tag, ".flags"}, {28'd0, done, pass, fail, timeout}, {28'd0, exp_dpft});
    endtask

`ifndef TEST_STATUS_UART_EN
    int uart_bad = 0;
    always @(negedge clk) begin
        if (serial_out !== 1'b1 || uart_busy !== 1'b0) uart_bad++;
    end
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_flags("rst", 4'b0000);
        check("rst.fail_code", fail_code, 32'd0);
        check("rst.cycle_count", cycle_count, 32'd0);
        check("rst.serial_out", {31'd0, serial_out}, 32'd1);
        check("rst.uart_busy", {31'd0, uart_busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // PASS at cycle 50, then hold
        tick(50);
        check("s1.count_pre", cycle_count, 32'd50);
        write_csr(32'd1);
        @(negedge clk);
        check_flags("s1", 4'b1100);
        check("s1.cycle_count", cycle_count, 32'd50);
        check("s1.fail_code", fail_code, 32'd0);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if ({done, pass, fail, timeout} !== 4'b1100 || cycle_count !== 32'd50 ||
                fail_code !== 32'd0) bad++;
        end
        check("s1.hold_bad_cycles", bad, 32'd0);

        // Zero write ignored, then FAIL with 0xDEAD; later PASS write ignored
        apply_reset();
        tick(20);
        write_csr(32'd0);
        @(negedge clk);
        check_flags("s2.after_zero", 4'b0000);
        check("s2.count_21", cycle_count, 32'd21);
        tick(9);
        check("s2.count_30", cycle_count, 32'd30);
        write_csr(32'h0000_DEAD);
        @(negedge clk);
        check_flags("s2.fail", 4'b1010);
        check("s2.fail_code", fail_code, 32'h0000_DEAD);
        check("s2.cycle_count", cycle_count, 32'd30);
        write_csr(32'd1);
        tick(3);
        check_flags("s2.late_write", 4'b1010);
        check("s2.fail_code_hold", fail_code, 32'h0000_DEAD);
        check("s2.count_hold", cycle_count, 32'd30);

        // TIMEOUT with no writes
        apply_reset();
        tick(999);
        check("s3.count_999", cycle_count, 32'd999);
        check_flags("s3.pre_timeout", 4'b0000);
        tick(1);
        check_flags("s3.timeout", 4'b1001);
        check("s3.count_frozen", cycle_count, 32'd999);
        tick(20);
        check("s3.count_hold", cycle_count, 32'd999);
        check_flags("s3.hold", 4'b1001);

        // Write in the timeout cycle wins
        apply_reset();
        tick(999);
        write_csr(32'd1);
        @(negedge clk);
        check_flags("s3b.write_wins", 4'b1100);
        check("s3b.cycle_count", cycle_count, 32'd999);

        // One-cycle reset out of PASS, then FAIL code 7
        apply_reset();
        @(negedge clk);
        check_flags("s4.after_rst", 4'b0000);
        check("s4.count_restart", cycle_count, 32'd0);
        check("s4.fail_code_clr", fail_code, 32'd0);
        tick(5);
        write_csr(32'd7);
        @(negedge clk);
        check_flags("s4.fail", 4'b1010);
        check("s4.fail_code", fail_code, 32'd7);
        check("s4.cycle_count", cycle_count, 32'd5);

`ifdef TEST_STATUS_UART_EN
        begin
            logic       samp [0:209];
            logic [7:0] exp_bytes [0:4];
            logic [7:0] byte_v;
            int         busy_cnt;

            exp_bytes[0] = 8'h50;
            exp_bytes[1] = 8'h00;
            exp_bytes[2] = 8'h00;
            exp_bytes[3] = 8'h00;
            exp_bytes[4] = 8'h12;
            apply_reset();
            tick(18);
            write_csr(32'd1);
            busy_cnt = 0;
            for (int i = 0; i < 210; i++) begin
                @(negedge clk);
                samp[i] = serial_out;
                if (uart_busy === 1'b1) busy_cnt++;
            end
            for (int b = 0; b < 5; b++) begin
                for (int k = 0; k < 8; k++) byte_v[k] = samp[(b * 10 + 1 + k) * 4 + 1];
                check($sformatf("s5.byte%0d", b), {24'd0, byte_v}, {24'd0, exp_bytes[b]});
                check($sformatf("s5.frame%0d", b),
                      {30'd0, samp[(b * 10) * 4 + 1], samp[(b * 10 + 9) * 4 + 1]}, 32'd1);
            end
            check("s5.busy_cycles", busy_cnt, 32'd200);
            check("s5.idle_after", {31'd0, samp[205]}, 32'd1);

            // Reset in the middle of the status byte
            apply_reset();
            tick(18);
            write_csr(32'd1);
            tick(6);
            @(negedge clk);
            check("s5.mid_serial", {31'd0, serial_out}, 32'd0);
            check("s5.mid_busy", {31'd0, uart_busy}, 32'd1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("s5.rst_serial", {31'd0, serial_out}, 32'd1);
            check("s5.rst_busy", {31'd0, uart_busy}, 32'd0);
            rst = 1'b0;
        end
`else
        tick(2);
        check("s6.uart_idle_bad_cycles", uart_bad, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
